ram_responder: RTL
==================

# ram_responder

Word-wide external-memory responder serving the cache-to-RAM interface used by the team's caches: accepts one read or write request at a time, waits a programmable number of cycles, then completes with a one-cycle valid pulse. Sits on the far side of a cache's ram_* ports as the backing store in simulation and in FPGA builds. It is non-pipelined; the cache issues the next word only after seeing valid.

## Interface
- ADDRESS_WIDTH, 16, byte address width; matches the cache.
- MEM_WORDS_LOG2, 10, log2 of stored 32-bit words; must be ≤ ADDRESS_WIDTH-2 (elaboration $fatal otherwise).
- READ_LATENCY, 4, cycles from request acceptance to read valid; must be ≥ 1.
- WRITE_LATENCY, 4, cycles from request acceptance to write valid; must be ≥ 1.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- ram_address  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored; bits above MEM_WORDS_LOG2+1 ignored (aliasing).
- ram_rd  in  1  read request.
- ram_wr  in  1  write request.
- ram_data_wr  in  32  write data.
- ram_data_rd  out  32  read data, valid when ram_data_valid is high after a read.
- ram_data_valid  out  1  one-cycle completion pulse for the accepted request.
- protocol_error  out  1  sticky; set when ram_rd and ram_wr are both high in IDLE.

## Operation
- States: IDLE, BUSY, RESPOND.
- IDLE: on an edge with exactly one of ram_rd/ram_wr high, capture word index = ram_address[MEM_WORDS_LOG2+1:2], op, ram_data_wr; load counter = LAT-1 (LAT per op). Next state BUSY when LAT > 1; RESPOND when LAT = 1.
- IDLE with both high: no acceptance, protocol_error <= 1, stay IDLE.
- BUSY: decrement counter; at 1 → RESPOND next. Inputs ignored.
- RESPOND: ram_data_valid = 1 for this cycle only, then IDLE. Inputs ignored in this cycle (a request held or raised here is accepted in the following IDLE cycle if still present).
- Read: ram_data_rd loaded from array[index] on the edge entering RESPOND; holds its value until the next read completes (writes do not change it).
- Write: array[index] <= captured data on the edge entering RESPOND; a read accepted afterwards returns the new value.
- Request strobes need only be high for the acceptance cycle; dropping them afterwards does not cancel the request.
- Array contents are not cleared by reset; initialised to zero at time 0.

## Timing
- Reset values: ram_data_valid 0, ram_data_rd 0, protocol_error 0, state IDLE, counter 0.
- Request high in cycle N (IDLE) → ram_data_valid high in cycle N+LAT exactly.
- Minimum request-to-request spacing: LAT+1 cycles (acceptance is never in RESPOND).
- Cache pattern: strobe pulses one cycle, re-asserted with new address the cycle after valid → accepted immediately (state already IDLE).
- rst mid-operation: outstanding request dropped, no valid pulse, pending write not committed, protocol_error cleared.
- Counter width: clog2(max(READ_LATENCY, WRITE_LATENCY)+1).

## Structure
- Shared cache_pkg: RAM word width constant (32) and the ram-interface op enum (OP_RD, OP_WR) reused by caches and benches; the FSM state enum stays local.
- One sub-module, word_ram: single-port 2**MEM_WORDS_LOG2 × 32 array, synchronous write, registered read; ram_responder holds FSM, counter and capture registers.

## Test plan
- Write 0xDEADBEEF to 0x0010 (WRITE_LATENCY=4, wr pulsed cycle 10) → valid only in cycle 14; read 0x0010 → ram_data_rd = 0xDEADBEEF with valid 4 cycles after acceptance.
- Aliasing: write 0x11111111 to 0x0004, read 0x1004 (MEM_WORDS_LOG2=10) → 0x11111111; read 0x0007 → same word.
- LAT=1 back-to-back: drive a 4-word line fetch exactly as the cache does (strobe re-raised after each valid) → four valids in cycles 1, 3, 5, 7 after the first request, data in address order.
- rd and wr both high in IDLE → no valid ever issued, protocol_error = 1 and stays 1 until rst.
- Assert rst in the BUSY cycle of a write of 0xCAFEF00D to 0x0020 → no valid pulse; subsequent read of 0x0020 returns the prior value (0x00000000).
- Strobe held high through BUSY/RESPOND (READ_LATENCY=3) → exactly one valid per 4 cycles, second request accepted the cycle after valid.

Source files
------------

// File: rtl/cache_pkg.sv
// Types and constants shared by the caches, their RAM-side
// responders and the benches that drive them.
package cache_pkg;

    localparam int RAM_WORD_W = 32;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } ram_op_e;

endpackage

// File: rtl/word_ram.sv
// Single-port word array with synchronous write and a registered read port.
// Contents start at zero and survive reset; only the read register resets.
module word_ram
    import cache_pkg::*;
#(
    parameter int WORDS_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  ram_op_e                i_op,
    input  logic [WORDS_LOG2-1:0]  i_idx,
    input  logic [RAM_WORD_W-1:0]  i_wdata,
    output logic [RAM_WORD_W-1:0]  o_rdata
);

    localparam int DEPTH = 2 ** WORDS_LOG2;

    logic [RAM_WORD_W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [RAM_WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_op == OP_WR) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en && i_op == OP_RD) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Non-pipelined RAM responder: one request at a time, fixed per-op latency,
// single-cycle valid pulse on completion.
module ram_responder
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [RAM_WORD_W-1:0]    ram_data_wr,
    output logic [RAM_WORD_W-1:0]    ram_data_rd,
    output logic                     ram_data_valid,
    output logic                     protocol_error
);

    if (MEM_WORDS_LOG2 > ADDRESS_WIDTH - 2) begin : g_bad_words
        $fatal(1, "MEM_WORDS_LOG2 exceeds ADDRESS_WIDTH-2");
    end
    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_lat
        $fatal(1, "latencies must be at least 1");
    end

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ?
                             READ_LATENCY : WRITE_LATENCY;
    localparam int CW = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]                r_state;
    logic [CW-1:0]             r_cnt;
    logic [MEM_WORDS_LOG2-1:0] r_idx;
    ram_op_e                   r_op;
    logic [RAM_WORD_W-1:0]     r_wdata;
    logic                      r_perr;

    logic                      w_idle;
    logic                      w_busy;
    logic                      w_accept;
    ram_op_e                   w_new_op;
    logic                      w_new_lat1;
    logic [CW-1:0]             w_load;
    logic [MEM_WORDS_LOG2-1:0] w_new_idx;
    logic                      w_go;
    ram_op_e                   w_op;
    logic [MEM_WORDS_LOG2-1:0] w_idx;
    logic [RAM_WORD_W-1:0]     w_wdata;
    logic                      w_unused_addr;

    assign w_idle     = (r_state == S_IDLE);
    assign w_busy     = (r_state == S_BUSY);
    assign w_accept   = w_idle && (ram_rd ^ ram_wr);
    assign w_new_op   = ram_wr ? OP_WR : OP_RD;
    assign w_new_lat1 = ram_wr ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
    assign w_load     = ram_wr ? WR_LOAD : RD_LOAD;
    assign w_new_idx  = ram_address[MEM_WORDS_LOG2+1:2];
    assign w_unused_addr = ^ram_address;

    // The array is touched on the edge that enters RESPOND; with a
    // latency of one that is the acceptance edge itself, so bypass
    // the capture registers in IDLE.
    assign w_go = !rst &&
                  ((w_accept && w_new_lat1) || (w_busy && r_cnt == CNT_ONE));
    assign w_op    = w_idle ? w_new_op    : r_op;
    assign w_idx   = w_idle ? w_new_idx   : r_idx;
    assign w_wdata = w_idle ? ram_data_wr : r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_op    <= OP_RD;
            r_wdata <= '0;
            r_perr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ram_rd && ram_wr) begin
                        r_perr <= 1'b1;
                    end else if (w_accept) begin
                        r_idx   <= w_new_idx;
                        r_op    <= w_new_op;
                        r_wdata <= ram_data_wr;
                        r_cnt   <= w_load;
                        r_state <= w_new_lat1 ? S_RESPOND : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_RESPOND;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    word_ram #(
        .WORDS_LOG2 (MEM_WORDS_LOG2)
    ) u_word_ram (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_go),
        .i_op    (w_op),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (ram_data_rd)
    );

    assign ram_data_valid = (r_state == S_RESPOND);
    assign protocol_error = r_perr;

endmodule
